// File: rtl/cp0_regfile.sv
// MIPS coprocessor-0 register file: exception commit, MTC0/MFC0 and the Count/Compare timer.
// Define CP0_TIMER_INT_EN to route the timer interrupt into Cause[15] and Cause.TI.
module cp0_regfile #(
  parameter logic [31:0] PRID_VAL   = 32'h0000_4220,
  parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [4:0]  raddr_i,
  input  logic [31:0] data_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] pc_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] bad_addr_i,
  output logic [31:0] data_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] badvaddr_o,
  output logic        timer_int_o
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;
  localparam logic [4:0] REG_CONFIG   = 5'd16;
  localparam logic [4:0] REG_NONE     = 5'd0;

  localparam logic [31:0] EXC_NONE = 32'h0000_0000;
  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  localparam logic [31:0] STATUS_RST   = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;

  // BEV is hard-wired high; only IM, EXL and IE are software-writable.
  function automatic logic [31:0] status_wr(input logic [31:0] d);
    return (d & STATUS_WMASK) | STATUS_RST;
  endfunction

  logic [31:0] status_r, cause_r, epc_r, count_r, compare_r, badvaddr_r;
  logic        tick_r, timer_int_r;
  logic [31:0] status_s, cause_s, epc_s, count_s, compare_s, badvaddr_s;
  logic        tick_s, timer_int_s;
  logic [4:0]  wsel_s;

  // Next-state for all CP0 state: timer, MTC0, then exception commit.
  always_comb begin
    status_s   = status_r;
    cause_s    = cause_r;
    epc_s      = epc_r;
    compare_s  = compare_r;
    badvaddr_s = badvaddr_r;
    tick_s     = ~tick_r;
    if (tick_r) begin
      count_s = count_r + 32'd1;
    end else begin
      count_s = count_r;
    end

    // Any exception or ERET squashes the MTC0, including its Compare clear.
    if (we_i && (excepttype_i == EXC_NONE)) begin
      wsel_s = waddr_i;
    end else begin
      wsel_s = REG_NONE;
    end

    if (wsel_s == REG_COMPARE) begin
      timer_int_s = 1'b0;
    end else if (count_r == compare_r) begin
      timer_int_s = 1'b1;
    end else begin
      timer_int_s = timer_int_r;
    end

    cause_s[14:10] = int_i[4:0];
`ifdef CP0_TIMER_INT_EN
    cause_s[15] = int_i[5] | timer_int_r;
    cause_s[30] = timer_int_s;
`else
    cause_s[15] = int_i[5];
    cause_s[30] = 1'b0;
`endif

    case (wsel_s)
      REG_COUNT:   count_s      = data_i;
      REG_COMPARE: compare_s    = data_i;
      REG_STATUS:  status_s     = status_wr(data_i);
      REG_CAUSE:   cause_s[9:8] = data_i[9:8];
      REG_EPC:     epc_s        = data_i;
      default:     wsel_s       = REG_NONE;
    endcase

    case (excepttype_i)
      EXC_NONE: status_s[1] = status_s[1];
      EXC_ERET: status_s[1] = 1'b0;
      default: begin
        // A nested exception keeps the original return address.
        if (status_r[1]) begin
          epc_s       = epc_r;
          cause_s[31] = cause_r[31];
        end else if (is_in_delayslot_i) begin
          epc_s       = pc_i - 32'd4;
          cause_s[31] = 1'b1;
        end else begin
          epc_s       = pc_i;
          cause_s[31] = 1'b0;
        end
        status_s[1] = 1'b1;
        if (excepttype_i == EXC_INT) begin
          cause_s[6:2] = 5'd0;
        end else begin
          cause_s[6:2] = excepttype_i[4:0];
        end
        if ((excepttype_i == EXC_ADEL) || (excepttype_i == EXC_ADES)) begin
          badvaddr_s = bad_addr_i;
        end else begin
          badvaddr_s = badvaddr_r;
        end
      end
    endcase
  end

  // CP0 state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_r    <= STATUS_RST;
      cause_r     <= 32'h0000_0000;
      epc_r       <= 32'h0000_0000;
      count_r     <= 32'h0000_0000;
      compare_r   <= 32'h0000_0000;
      badvaddr_r  <= 32'h0000_0000;
      tick_r      <= 1'b0;
      timer_int_r <= 1'b0;
    end else begin
      status_r    <= status_s;
      cause_r     <= cause_s;
      epc_r       <= epc_s;
      count_r     <= count_s;
      compare_r   <= compare_s;
      badvaddr_r  <= badvaddr_s;
      tick_r      <= tick_s;
      timer_int_r <= timer_int_s;
    end
  end

  // MFC0 read port; deliberately shows pre-write state.
  always_comb begin
    case (raddr_i)
      REG_BADVADDR: data_o = badvaddr_r;
      REG_COUNT:    data_o = count_r;
      REG_COMPARE:  data_o = compare_r;
      REG_STATUS:   data_o = status_r;
      REG_CAUSE:    data_o = cause_r;
      REG_EPC:      data_o = epc_r;
      REG_PRID:     data_o = PRID_VAL;
      REG_CONFIG:   data_o = CONFIG_VAL;
      default:      data_o = 32'h0000_0000;
    endcase
  end

  assign status_o    = status_r;
  assign cause_o     = cause_r;
  assign epc_o       = epc_r;
  assign count_o     = count_r;
  assign compare_o   = compare_r;
  assign badvaddr_o  = badvaddr_r;
  assign timer_int_o = timer_int_r;

endmodule

// File: tb/tb_cp0_regfile.sv
// Scoreboard bench for cp0_regfile: expectations queued with stimulus, popped after each edge.
`timescale 1ns/1ps
module tb_cp0_regfile;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        we_i;
  logic [4:0]  waddr_i, raddr_i;
  logic [31:0] data_i, excepttype_i, pc_i, bad_addr_i;
  logic [5:0]  int_i;
  logic        is_in_delayslot_i;
  logic [31:0] data_o, status_o, cause_o, epc_o, count_o, compare_o, badvaddr_o;
  logic        timer_int_o;

`ifdef CP0_TIMER_INT_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  localparam int S_DATA = 0, S_STATUS = 1, S_CAUSE = 2, S_EPC = 3,
                 S_COUNT = 4, S_COMPARE = 5, S_BADV = 6, S_TIMER = 7;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_checks = 0;
  int  n_fail = 0;

  cp0_regfile dut (
    .clk(clk), .resetn(resetn), .we_i(we_i), .waddr_i(waddr_i), .raddr_i(raddr_i),
    .data_i(data_i), .int_i(int_i), .excepttype_i(excepttype_i), .pc_i(pc_i),
    .is_in_delayslot_i(is_in_delayslot_i), .bad_addr_i(bad_addr_i), .data_o(data_o),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .count_o(count_o),
    .compare_o(compare_o), .badvaddr_o(badvaddr_o), .timer_int_o(timer_int_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] obs_of(input int sel);
    case (sel)
      S_DATA:    return data_o;
      S_STATUS:  return status_o;
      S_CAUSE:   return cause_o;
      S_EPC:     return epc_o;
      S_COUNT:   return count_o;
      S_COMPARE: return compare_o;
      S_BADV:    return badvaddr_o;
      S_TIMER:   return {31'd0, timer_int_o};
      default:   return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic push(input string n, input int s, input logic [31:0] e);
    sb.push_back('{name: n, sel: s, exp: e});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we_i = 1'b0; waddr_i = 5'd0; data_i = 32'd0; excepttype_i = 32'd0;
    pc_i = 32'd0; is_in_delayslot_i = 1'b0; bad_addr_i = 32'd0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    idle();
    we_i = 1'b1; waddr_i = a; data_i = d;
  endtask

  task automatic exc(input logic [31:0] code, input logic [31:0] pc, input logic ds,
                     input logic [31:0] bad);
    excepttype_i = code; pc_i = pc; is_in_delayslot_i = ds; bad_addr_i = bad;
  endtask

  task automatic do_reset();
    idle();
    int_i = 6'd0; raddr_i = 5'd0;
    @(negedge clk); resetn = 1'b0;
    @(negedge clk); resetn = 1'b1;
  endtask

  task automatic test_reset();
    sb_t e; logic [31:0] obs;
    logic [4:0]  ra [10] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd0, 5'd31};
    logic [31:0] rv [10] = '{32'h0, 32'h0, 32'h0, 32'h0040_0000, 32'h0, 32'h0,
                             32'h0000_4220, 32'h0000_8000, 32'h0, 32'h0};
    do_reset();
    mtc0(5'd14, 32'h0000_1234); step();
    mtc0(5'd12, 32'hffff_ffff); step();
    idle(); int_i = 6'h3f; step();
    @(negedge clk); resetn = 1'b0; #1;
    push("async_status", S_STATUS, 32'h0040_0000);
    push("async_epc", S_EPC, 32'h0);
    push("async_cause", S_CAUSE, 32'h0);
    push("async_count", S_COUNT, 32'h0);
    push("async_timer", S_TIMER, 32'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = obs_of(e.sel); n_checks++;
      if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs, e.exp); end
    end
    int_i = 6'd0;
    for (int i = 0; i < 10; i++) begin
      raddr_i = ra[i];
      push($sformatf("reset_read_%0d", ra[i]), S_DATA, rv[i]);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front(); obs = obs_of(e.sel); n_checks++;
        if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs, e.exp); end
      end
    end
    @(negedge clk); resetn = 1'b1;
    push("count_after_10", S_COUNT, 32'd5);
    push("timer_reset_match", S_TIMER, 32'd1);
    for (int i = 0; i < 10; i++) step();
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = obs_of(e.sel); n_checks++;
      if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs, e.exp); end
    end
  endtask

  task automatic test_exception();
    sb_t e; logic [31:0] obs;
    do_reset();
    for (int s = 0; s < 5; s++) begin
      idle();
      case (s)
        0: begin mtc0(5'd11, 32'hffff_0000); push("exc_cmp", S_COMPARE, 32'hffff_0000); end
        1: begin
          exc(32'hc, 32'hbfc0_0100, 1'b1, 32'h0);
          push("ov_epc", S_EPC, 32'hbfc0_00fc);
          push("ov_cause", S_CAUSE, 32'h8000_0030);
          push("ov_status", S_STATUS, 32'h0040_0002);
        end
        2: begin
          exc(32'h8, 32'h1234_5678, 1'b0, 32'h0);
          push("nested_epc", S_EPC, 32'hbfc0_00fc);
          push("nested_cause", S_CAUSE, 32'h8000_0020);
          push("nested_status", S_STATUS, 32'h0040_0002);
        end
        3: begin
          exc(32'he, 32'h5555_0000, 1'b1, 32'h0);
          push("eret_status", S_STATUS, 32'h0040_0000);
          push("eret_epc", S_EPC, 32'hbfc0_00fc);
          push("eret_cause", S_CAUSE, 32'h8000_0020);
        end
        default: begin
          exc(32'h1, 32'h0000_0100, 1'b0, 32'h0);
          push("int_epc", S_EPC, 32'h0000_0100);
          push("int_cause", S_CAUSE, 32'h0000_0000);
          push("int_status", S_STATUS, 32'h0040_0002);
        end
      endcase
      step();
      while (sb.size() > 0) begin
        e = sb.pop_front(); obs = obs_of(e.sel); n_checks++;
        if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs, e.exp); end
      end
    end
  endtask

  task automatic test_addr_err();
    sb_t e; logic [31:0] obs;
    do_reset();
    for (int s = 0; s < 5; s++) begin
      idle();
      case (s)
        0: mtc0(5'd11, 32'hffff_0000);
        1: begin mtc0(5'd14, 32'h1111_1111); push("pre_epc", S_EPC, 32'h1111_1111); end
        2: begin
          mtc0(5'd14, 32'hdead_beef);
          exc(32'h4, 32'h0000_2000, 1'b0, 32'h8000_0003);
          push("adel_badv", S_BADV, 32'h8000_0003);
          push("adel_cause", S_CAUSE, 32'h0000_0010);
          push("adel_epc_drop_mtc0", S_EPC, 32'h0000_2000);
        end
        3: begin
          mtc0(5'd12, 32'h0000_0000);
          exc(32'h5, 32'h0000_3000, 1'b0, 32'h0000_0004);
          push("ades_badv", S_BADV, 32'h0000_0004);
          push("ades_cause", S_CAUSE, 32'h0000_0014);
          push("ades_status_drop_mtc0", S_STATUS, 32'h0040_0002);
          push("ades_epc_nested", S_EPC, 32'h0000_2000);
        end
        default: begin
          exc(32'ha, 32'h0000_4000, 1'b0, 32'h0000_ffff);
          push("ri_badv_kept", S_BADV, 32'h0000_0004);
          push("ri_cause", S_CAUSE, 32'h0000_0028);
        end
      endcase
      step();
      while (sb.size() > 0) begin
        e = sb.pop_front(); obs = obs_of(e.sel); n_checks++;
        if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs, e.exp); end
      end
    end
  endtask

  task automatic test_timer();
    sb_t e; logic [31:0] obs;
    do_reset();
    for (int ed = 1; ed <= 19; ed++) begin
      idle();
      if (ed == 1) begin
        mtc0(5'd11, 32'd6);
        push("clear_beats_match_e1", S_TIMER, 32'd0);
      end else if (ed <= 15) begin
        push($sformatf("timer_e%0d", ed), S_TIMER, {31'd0, ed >= 13});
        push($sformatf("cause_e%0d", ed), S_CAUSE,
             TIMER_EN ? ({1'b0, ed >= 13, 29'd0} | {16'd0, ed >= 14, 15'd0}) : 32'd0);
        if (ed == 12) push("count_hits_6", S_COUNT, 32'd6);
      end else if (ed == 16) begin
        mtc0(5'd11, 32'h0000_0100);
        push("cmp_write_clears", S_TIMER, 32'd0);
        push("cmp_val", S_COMPARE, 32'h0000_0100);
      end else if (ed == 17) begin
        mtc0(5'd9, 32'h0000_0100);
        push("count_load", S_COUNT, 32'h0000_0100);
      end else if (ed == 18) begin
        mtc0(5'd11, 32'h0000_0100);
        push("clear_beats_match", S_TIMER, 32'd0);
        push("count_inc_after_load", S_COUNT, 32'h0000_0101);
      end else begin
        push("timer_stays_low", S_TIMER, 32'd0);
      end
      step();
      while (sb.size() > 0) begin
        e = sb.pop_front(); obs = obs_of(e.sel); n_checks++;
        if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs, e.exp); end
      end
    end
  endtask

  task automatic test_mtc0();
    sb_t e; logic [31:0] obs;
    do_reset();
    for (int s = 0; s < 6; s++) begin
      idle();
      case (s)
        0: mtc0(5'd11, 32'hffff_0000);
        1: begin
          mtc0(5'd12, 32'hffff_ffff);
          push("status_mask", S_STATUS, 32'h0040_ff03);
        end
        2: begin
          mtc0(5'd13, 32'hffff_ffff); int_i = 6'b010101;
          push("cause_sw_ip_and_hw", S_CAUSE, 32'h0000_5700);
        end
        3: begin
          mtc0(5'd14, 32'habcd_0123); int_i = 6'b100000; raddr_i = 5'd14;
          #1;
          push("mfc0_no_forward", S_DATA, 32'h0000_0000);
          while (sb.size() > 0) begin
            e = sb.pop_front(); obs = obs_of(e.sel); n_checks++;
            if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs, e.exp); end
          end
          push("mfc0_epc", S_DATA, 32'habcd_0123);
          push("cause_ip7_ext", S_CAUSE, 32'h0000_8300);
        end
        4: begin
          mtc0(5'd8, 32'hffff_ffff); raddr_i = 5'd12;
          push("badv_ro", S_BADV, 32'h0000_0000);
          push("mfc0_status", S_DATA, 32'h0040_ff03);
        end
        default: begin
          mtc0(5'd15, 32'h0000_0000); raddr_i = 5'd15;
          push("prid_ro", S_DATA, 32'h0000_4220);
        end
      endcase
      step();
      while (sb.size() > 0) begin
        e = sb.pop_front(); obs = obs_of(e.sel); n_checks++;
        if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs, e.exp); end
      end
    end
    int_i = 6'd0;
  endtask

  task automatic test_count_wrap();
    sb_t e; logic [31:0] obs;
    logic [31:0] exp_cnt [2:8] = '{32'hffff_ffff, 32'hffff_ffff, 32'h0, 32'h0,
                                   32'h50, 32'h50, 32'h51};
    do_reset();
    for (int ed = 1; ed <= 8; ed++) begin
      idle();
      if (ed == 1) mtc0(5'd11, 32'hffff_0000);
      else if (ed == 2) mtc0(5'd9, 32'hffff_ffff);
      else if (ed == 6) mtc0(5'd9, 32'h0000_0050);
      else idle();
      if (ed >= 2) push($sformatf("count_e%0d", ed), S_COUNT, exp_cnt[ed]);
      step();
      while (sb.size() > 0) begin
        e = sb.pop_front(); obs = obs_of(e.sel); n_checks++;
        if (obs !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs, e.exp); end
      end
    end
  endtask

  initial begin
    idle();
    int_i = 6'd0; raddr_i = 5'd0;
    test_reset();
    test_exception();
    test_addr_err();
    test_timer();
    test_mtc0();
    test_count_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
